// File: rtl/wmem_pkg.sv
// Shared types and helpers for the streaming weight store.
// Holds the FSM state encoding, the default weight type and the parity helper.
package wmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int PAR_MAX_W      = 64;

    typedef logic signed [DEF_DATA_WIDTH-1:0] weight_t;

    // Even parity: the stored bit makes the XOR of data plus parity zero.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/wmem_bank.sv
// One weight bank: single write port, single registered read port.
// The read register doubles as the lane's output holding register.
module wmem_bank
    import wmem_pkg::*;
#(
    parameter int DEPTH  = 30,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage is deliberately left out of reset so weights survive a stream abort.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_ren) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/w_mem_stream.sv
// Writable per-neuron weight store that streams one index per beat to the MAC array.
// Optional WMEM_PARITY_EN adds a stored even-parity bit per entry and a par_err output.
module w_mem_stream
    import wmem_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_WEIGHTS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_W      = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1,
    parameter int CHAN_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wen,
    input  logic [CHAN_W-1:0]                 wchan,
    input  logic [ADDR_W-1:0]                 wadd,
    input  logic [DATA_WIDTH-1:0]             win,
    input  logic                              start,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDR_W-1:0]                 out_idx,
    output logic                              out_last,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] wout,
    output logic                              done,
`ifdef WMEM_PARITY_EN
    output logic [NUM_NEURONS-1:0]            par_err,
`endif
    output logic                              wr_err
);

`ifdef WMEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W-1:0] r_idx;
    logic              r_valid;
    logic              r_last;
    logic              r_done;
    logic              r_wr_err;

    logic              w_in_range;
    logic              w_wr_ok;
    logic              w_issue;
    logic [MEM_W-1:0]  w_wdata;
    logic [MEM_W-1:0]  w_rdata [NUM_NEURONS];

    assign w_in_range = (32'(wchan) < NUM_NEURONS) && (32'(wadd) < NUM_WEIGHTS);
    assign w_wr_ok    = wen && (r_state == IDLE) && w_in_range;
    assign w_issue    = (r_state == STREAM) && (!r_valid || out_ready);

`ifdef WMEM_PARITY_EN
    assign w_wdata = {even_parity(PAR_MAX_W'(win)), win};
`else
    assign w_wdata = win;
`endif

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_bank
        wmem_bank #(
            .DEPTH  (NUM_WEIGHTS),
            .WIDTH  (MEM_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_wen   (w_wr_ok && (wchan == CHAN_W'(n))),
            .i_waddr (wadd),
            .i_wdata (w_wdata),
            .i_ren   (w_issue),
            .i_raddr (r_rp),
            .o_rdata (w_rdata[n])
        );

        assign wout[n*DATA_WIDTH +: DATA_WIDTH] = w_rdata[n][DATA_WIDTH-1:0];
`ifdef WMEM_PARITY_EN
        assign par_err[n] = r_valid && even_parity(PAR_MAX_W'(w_rdata[n]));
`endif
    end

    // The read pointer saturates at the last index; DRAIN holds that beat until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rp     <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_wr_err <= wen && !w_wr_ok;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= STREAM;
                        r_rp    <= '0;
                    end
                end
                STREAM: begin
                    if (w_issue) begin
                        r_idx   <= r_rp;
                        r_last  <= (r_rp == LAST_IDX);
                        r_valid <= 1'b1;
                        if (r_rp == LAST_IDX) begin
                            r_state <= DRAIN;
                        end else begin
                            r_rp <= r_rp + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign done      = r_done;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_w_mem_stream.sv
// Directed self-checking bench for w_mem_stream against a bench-side weight model.
// Build with WMEM_PARITY_EN defined to also exercise the parity error path.
module tb_w_mem_stream;
    import wmem_pkg::*;

    localparam int NN = 4;
    localparam int NW = 30;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wen;
    logic [CW-1:0]    wchan;
    logic [AW-1:0]    wadd;
    logic [DW-1:0]    win;
    logic             start;
    logic             busy;
    logic             outValid;
    logic             outReady;
    logic [AW-1:0]    outIdx;
    logic             outLast;
    logic [NN*DW-1:0] wout;
    logic             done;
    logic             wrErr;
`ifdef WMEM_PARITY_EN
    logic [NN-1:0]    parErr;
`endif

    int          checkCount  = 0;
    int          failCount   = 0;
    int          parFlipIdx  = -1;
    logic [DW-1:0] expMem [NN][NW];

    w_mem_stream #(
        .NUM_NEURONS (NN),
        .NUM_WEIGHTS (NW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .wchan     (wchan),
        .wadd      (wadd),
        .win       (win),
        .start     (start),
        .busy      (busy),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_idx   (outIdx),
        .out_last  (outLast),
        .wout      (wout),
        .done      (done),
`ifdef WMEM_PARITY_EN
        .par_err   (parErr),
`endif
        .wr_err    (wrErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one IDLE-cycle command, then checks wr_err and updates the model.
    task automatic applyStimulus(input logic wenV, input logic [CW-1:0] chanV, input logic [AW-1:0] addrV,
                                 input logic [DW-1:0] dataV, input logic startV);
        wen   = wenV;
        wchan = chanV;
        wadd  = addrV;
        win   = dataV;
        start = startV;
        @(negedge clk);
        wen   = 1'b0;
        start = 1'b0;
        checkOutput("wr_err", 64'(wrErr), 64'(wenV && (addrV >= 5'd30)));
        if (wenV && (addrV < 5'd30)) expMem[chanV][addrV] = dataV;
    endtask

    task automatic streamAndCheck(input int mode, input bit injectWrite, input bit startWrite,
                                  input bit injectStart, input int abortAt);
        int          expIdx;
        bit          finished;
        bit          readyNow;
        bit          aborted;
        logic [NN*DW-1:0] expWout;
        if (startWrite) applyStimulus(1'b1, 2'd2, 5'd0, 16'hBEEF, 1'b1);
        else            applyStimulus(1'b0, 2'd0, 5'd0, 16'h0000, 1'b1);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("valid_not_yet", 64'(outValid), 64'd0);
        outReady = 1'b0;
        @(negedge clk);
        expIdx   = 0;
        finished = 1'b0;
        aborted  = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            readyNow = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (c == 0) checkOutput("first_beat_valid", 64'(outValid), 64'd1);
            if (done) begin
                checkOutput("beats_before_done", 64'(expIdx), 64'(NW));
                checkOutput("valid_at_done", 64'(outValid), 64'd0);
                checkOutput("busy_at_done", 64'(busy), 64'd0);
                finished = 1'b1;
            end else if (outValid) begin
                if (expIdx >= NW) begin
                    checkOutput("extra_beat", 64'(outValid), 64'd0);
                end else if (abortAt >= 0 && expIdx == abortAt) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_valid", 64'(outValid), 64'd0);
                    checkOutput("rst_busy", 64'(busy), 64'd0);
                    checkOutput("rst_wout", 64'(wout), 64'd0);
                    checkOutput("rst_idx", 64'(outIdx), 64'd0);
                    @(negedge clk);
                    checkOutput("rst_no_done", 64'(done), 64'd0);
                    rst      = 1'b0;
                    finished = 1'b1;
                    aborted  = 1'b1;
                end else begin
                    for (int n = 0; n < NN; n++) expWout[n*DW +: DW] = expMem[n][expIdx];
                    checkOutput("beat_idx", 64'(outIdx), 64'(expIdx));
                    checkOutput("beat_last", 64'(outLast), 64'(expIdx == NW - 1));
                    checkOutput("beat_wout", 64'(wout), 64'(expWout));
`ifdef WMEM_PARITY_EN
                    checkOutput("par_err", 64'(parErr), (expIdx == parFlipIdx) ? 64'h2 : 64'h0);
`endif
                    if (readyNow) expIdx++;
                end
            end
            if (injectWrite && c == 6) checkOutput("wr_err_stream", 64'(wrErr), 64'd1);
            if (injectWrite && c == 7) checkOutput("wr_err_pulse", 64'(wrErr), 64'd0);
            if (!finished) begin
                outReady = readyNow;
                wen      = injectWrite && (c == 5);
                wchan    = 2'd0;
                wadd     = 5'd5;
                win      = 16'hDEAD;
                start    = injectStart && (c == 3);
                @(negedge clk);
            end
        end
        wen      = 1'b0;
        start    = 1'b0;
        outReady = 1'b0;
        checkOutput("stream_finished", 64'(finished), 64'd1);
        if (!aborted) begin
            @(negedge clk);
            checkOutput("done_pulse_end", 64'(done), 64'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        wen      = 1'b0;
        wchan    = '0;
        wadd     = '0;
        win      = '0;
        start    = 1'b0;
        outReady = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_valid", 64'(outValid), 64'd0);
        checkOutput("reset_last", 64'(outLast), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_wr_err", 64'(wrErr), 64'd0);
        checkOutput("reset_idx", 64'(outIdx), 64'd0);
        checkOutput("reset_wout", 64'(wout), 64'd0);
`ifdef WMEM_PARITY_EN
        checkOutput("reset_par_err", 64'(parErr), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] loading all banks");
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NW; i++) begin
                applyStimulus(1'b1, CW'(n), AW'(i), DW'(n * 256 + i), 1'b0);
            end
        end

        $display("[TB] full-rate stream");
        streamAndCheck(0, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] backpressure stream");
        streamAndCheck(1, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] rejected writes");
        streamAndCheck(0, 1'b1, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 2'd0, 5'd30, 16'h1111, 1'b0);
        applyStimulus(1'b0, 2'd0, 5'd0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 2'd3, 5'd31, 16'h2222, 1'b0);
        applyStimulus(1'b1, 2'd3, 5'd29, 16'h031D, 1'b0);

        $display("[TB] reset mid-stream");
        streamAndCheck(0, 1'b0, 1'b0, 1'b0, 12);
        streamAndCheck(0, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] start with write, ignored restart");
        streamAndCheck(0, 1'b0, 1'b1, 1'b1, -1);

`ifdef WMEM_PARITY_EN
        $display("[TB] parity error injection");
        dut.g_bank[1].u_bank.r_mem[7][0] = ~dut.g_bank[1].u_bank.r_mem[7][0];
        expMem[1][7][0] = ~expMem[1][7][0];
        parFlipIdx = 7;
        streamAndCheck(0, 1'b0, 1'b0, 1'b0, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
